// File: rtl/sel_pkg.sv
// rtl/sel_pkg.sv - shared constants and select clamping for the registered channel selector
// Purpose: mode encodings and the helper that maps an out-of-range select onto the last channel.
// Ports: none (package).
package sel_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Any select at or beyond the channel count routes the last channel.
  function automatic logic [31:0] clamp_sel(input logic [31:0] sel, input logic [31:0] n);
    return (sel < n) ? sel : (n - 32'd1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
// Purpose: grant the first requesting index at or after ptr, wrapping modulo N.
// Ports:
//   req     in  N   request per index
//   ptr     in  SW  highest-priority index (must be < N)
//   gnt_vld out 1   some request was granted
//   gnt_idx out SW  granted index (0 when gnt_vld = 0)
module rr_pick
  import sel_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);

  localparam logic [SW:0] NL = (SW+1)'(N);

  // One spare bit so ptr + offset (at most 2N-2) cannot overflow before the wrap.
  logic [SW:0] w_sum;

  // Walk offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    w_sum   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_sum = {1'b0, ptr} + (SW+1)'(i);
      if (w_sum >= NL) begin
        w_sum = w_sum - NL;
      end
      if (req[w_sum[SW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = w_sum[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/sel_rr.sv
// rtl/sel_rr.sv - N-channel registered selector with fixed or round-robin choice
// Purpose: pick one input channel per cycle and latch its data into a single output register.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_data   in  N*W   channel k at [k*W +: W]
//   in_valid  in  N     per-channel valid
//   in_ready  out N     per-channel ready, one-hot or zero
//   mode      in  1     0 = fixed select, 1 = round-robin
//   sel       in  SW    channel index in fixed mode
//   out_data  out W     registered data
//   out_chan  out SW    channel that produced out_data
//   out_valid out 1     output register full
//   out_ready in  1     consumer accepts
module sel_rr
  import sel_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [W-1:0]  w_ch [N];
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] r_chan;
  logic [W-1:0]  r_data;
  logic          r_valid;

  logic          w_load;
  logic [SW-1:0] w_fix_idx;
  logic          w_rr_vld;
  logic [SW-1:0] w_rr_idx;
  logic          w_gnt_vld;
  logic [SW-1:0] w_gnt_idx;
  logic          w_take;
  logic [SW-1:0] w_ptr_nxt;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign w_ch[k] = in_data[k*W +: W];
  end

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt_vld (w_rr_vld),
    .gnt_idx (w_rr_idx)
  );

  assign w_load    = !r_valid || out_ready;
  assign w_fix_idx = SW'(clamp_sel(32'(sel), 32'(N)));
  assign w_gnt_idx = (mode == MODE_RR) ? w_rr_idx : w_fix_idx;
  assign w_gnt_vld = (mode == MODE_RR) ? w_rr_vld : in_valid[w_fix_idx];
  // rst_n gates the handshake so no producer sees ready while the block is held in reset.
  assign w_take    = w_load && w_gnt_vld && rst_n;
  assign w_ptr_nxt = (w_gnt_idx == SW'(N - 1)) ? '0 : (w_gnt_idx + SW'(1));

  always_comb begin
    in_ready = '0;
    if (w_take) begin
      in_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_take) begin
        r_valid <= 1'b1;
        r_data  <= w_ch[w_gnt_idx];
        r_chan  <= w_gnt_idx;
        if (mode == MODE_RR) begin
          r_ptr <= w_ptr_nxt;
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_sel_rr.sv
// tb/tb_sel_rr.sv - directed table-driven bench for sel_rr
module tb_sel_rr;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid, out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3, out_ready3;

  sel_rr #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  sel_rr #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [1:0] e_ch;
    logic [7:0] e_d;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dat(input logic [1:0] c);
    case (c)
      2'd0:    return 8'h10;
      2'd1:    return 8'h21;
      2'd2:    return 8'h32;
      default: return 8'h43;
    endcase
  endfunction

  function automatic void add(input logic m, input logic [1:0] s, input logic [3:0] v,
                              input logic r, input logic [3:0] er, input logic eov,
                              input logic [1:0] ech);
    vec_t t;
    t.mode = m; t.sel = s; t.vld = v; t.ordy = r;
    t.e_rdy = er; t.e_ov = eov; t.e_ch = ech; t.e_d = dat(ech);
    vecs.push_back(t);
  endfunction

  initial begin
    // FIXED sweep: sel held 4 cycles per channel; ptr stays 0.
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 4; r++)
        add(1'b0, 2'(s), 4'hF, 1'b1, 4'(1 << s), 1'b1, 2'(s));
    // RR fairness from ptr 0.
    for (int k = 0; k < 8; k++)
      add(1'b1, 2'd0, 4'hF, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4));
    // RR skip and wrap, then only channel 3 valid.
    for (int k = 0; k < 2; k++) begin
      add(1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0);
      add(1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3);
    end
    for (int k = 0; k < 3; k++)
      add(1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3);
    // Mode switch: FIXED sel 2, then RR resumes at retained ptr 0.
    for (int k = 0; k < 3; k++)
      add(1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2);
    add(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0);
    // Backpressure: hold chan 0 (mode/sel changes ignored), then chan 1 with no gap.
    add(1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0);
    add(1'b0, 2'd3, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0);
    add(1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0);
    add(1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1);
    // No grant: output empties, data/chan hold.
    add(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1);
    add(1'b0, 2'd0, 4'b1110, 1'b1, 4'b0000, 1'b0, 2'd1);
    // Empty register loads even with out_ready low, then holds.
    add(1'b1, 2'd0, 4'hF, 1'b0, 4'b0100, 1'b1, 2'd2);
    add(1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2);

    in_data    = {8'h43, 8'h32, 8'h21, 8'h10};
    in_valid   = 4'hF;
    mode       = 1'b0;
    sel        = 2'd0;
    out_ready  = 1'b1;
    in_data3   = {8'hC2, 8'hB1, 8'hA0};
    in_valid3  = 3'b111;
    mode3      = 1'b0;
    sel3       = 2'd3;
    out_ready3 = 1'b1;
    rst_n      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_data", out_data, 8'h00);
    chk("reset out_chan", out_chan, 2'd0);
    chk("reset in_ready", in_ready, 4'b0000);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      in_valid  = vecs[i].vld;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].e_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("v%0d out_chan", i), out_chan, vecs[i].e_ch);
      chk($sformatf("v%0d out_data", i), out_data, vecs[i].e_d);
    end

    // Reset while FULL: immediate clear, and ptr (was 3) restarts at 0.
    in_valid  = 4'hF;
    out_ready = 1'b1;
    mode      = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("midreset out_valid", out_valid, 1'b0);
    chk("midreset out_data", out_data, 8'h00);
    chk("midreset out_chan", out_chan, 2'd0);
    chk("midreset in_ready", in_ready, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("postreset in_ready", in_ready, 4'b0001);
    @(posedge clk);
    #1;
    chk("postreset out_valid", out_valid, 1'b1);
    chk("postreset out_chan", out_chan, 2'd0);
    chk("postreset out_data", out_data, 8'h10);

    // N=3: select 3 is out of range and routes channel 2.
    #1;
    chk("n3 sel3 in_ready", in_ready3, 3'b100);
    @(posedge clk);
    #1;
    chk("n3 sel3 out_chan", out_chan3, 2'd2);
    chk("n3 sel3 out_data", out_data3, 8'hC2);
    sel3 = 2'd0;
    #1;
    chk("n3 sel0 in_ready", in_ready3, 3'b001);
    @(posedge clk);
    #1;
    chk("n3 sel0 out_chan", out_chan3, 2'd0);
    chk("n3 sel0 out_data", out_data3, 8'hA0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
